fsk_tx_sequencer: RTL and testbench
===================================

Name: fsk_tx_sequencer

Overview:
- Frame sequencer for the FSK transmit path.
- Accepts one byte per valid/ready handshake and serialises it as a 10-bit frame: start bit 0, 8 data bits LSB first, stop bit 1.
- Keys a square-wave carrier between a mark frequency (bit 1) and a space frequency (bit 0).
- Replaces ripple-derived clocks with clock enables and counters on the single system clock; sits between the byte source and the analog/output stage.

Parameters:
- BIT_CYCLES, 100: clk cycles per serial bit; must be >= 2.
- HALF_SPACE, 10: clk cycles per half-period of the space (bit 0) carrier; must be >= 1.
- HALF_MARK, 5: clk cycles per half-period of the mark (bit 1) carrier; must be >= 1.
- Counter widths are $clog2 of the respective maximum, minimum 1.

Ports:
- clk  in  1  system clock, all logic on posedge
- rst  in  1  asynchronous active-low reset
- tx_data  in  8  byte to transmit; sampled only on acceptance
- tx_valid  in  1  source has a byte
- tx_ready  out  1  sequencer can accept a byte
- fsk_out  out  1  keyed carrier output
- busy  out  1  frame in progress
- bit_tick  out  1  one-cycle pulse on the last cycle of every bit
- cur_bit  out  1  logical value of the bit currently being sent
- frame_done  out  1  one-cycle pulse on the last cycle of the stop bit

Behaviour:
- Reset (rst=0, asynchronous):
  - state=IDLE; all counters and the shift register cleared.
  - fsk_out=0, busy=0, bit_tick=0, frame_done=0, cur_bit=1, tx_ready=1.
- States and transitions:
  - IDLE -> START -> DATA -> STOP -> IDLE.
- IDLE:
  - tx_ready=1, busy=0, fsk_out held 0, carrier counter held 0.
  - Acceptance when tx_valid && tx_ready on cycle N: tx_data latched into the shift register.
  - Cycle N+1: state=START, busy=1, tx_ready=0, cur_bit=0.
- Bit timing:
  - bit_cnt runs 0..BIT_CYCLES-1 in START/DATA/STOP.
  - bit_tick=1 exactly when bit_cnt==BIT_CYCLES-1; bit_cnt then wraps to 0.
- START:
  - Lasts one bit; on bit_tick -> DATA with bit_idx=0.
- DATA:
  - cur_bit = shift_reg[0].
  - On bit_tick: shift right, bit_idx++.
  - On bit_tick with bit_idx==7 -> STOP.
- STOP:
  - cur_bit=1.
  - On bit_tick: frame_done=1, then IDLE next cycle.
- Frame length:
  - Exactly 10*BIT_CYCLES cycles from START entry to IDLE re-entry.
  - Next acceptance is possible at the earliest on the first IDLE cycle, i.e. 10*BIT_CYCLES+1 cycles after the previous acceptance.
- Carrier:
  - half = cur_bit ? HALF_MARK : HALF_SPACE.
  - car_cnt counts 0..half-1; when car_cnt==half-1, fsk_out toggles and car_cnt returns to 0.
  - On every bit boundary (bit_tick), car_cnt resets to 0 and fsk_out keeps its level (phase-continuous keying, no glitch).
  - On entering START, fsk_out=0, so the first rising edge of fsk_out occurs HALF_SPACE cycles after START entry.
  - On return to IDLE, fsk_out is forced to 0 on the IDLE entry cycle.
- Boundary conditions:
  - tx_valid while busy: ignored; the byte is not consumed (tx_ready=0).
  - tx_data changing after acceptance: no effect on the frame.
  - HALF_* greater than BIT_CYCLES: legal; fsk_out may not toggle within a bit.
  - Reset mid-frame: frame abandoned, all outputs return to reset values immediately; no frame_done.
  - bit_tick and a carrier toggle on the same cycle: the bit boundary rule wins; car_cnt goes to 0 and fsk_out holds.

Decomposition:
- Shared package fsk_pkg holds:
  - state enum (IDLE, START, DATA, STOP)
  - START_BIT=0, STOP_BIT=1, DATA_BITS=8, FRAME_BITS=10
- One sub-module fsk_carrier_gen:
  - inputs: clk, rst, enable, sel_mark, phase_reset
  - output: carrier
  - parameterised by HALF_MARK and HALF_SPACE
  - holds car_cnt and the toggle flop
- The sequencer owns the FSM, bit_cnt, bit_idx and the shift register.

Test Plan:
- Reset release with tx_valid=0 -> tx_ready=1, busy=0, fsk_out=0 for 1000 cycles.
- Send 8'hA5 with defaults:
  - cur_bit sequence 0,1,0,1,0,0,1,0,1,1, each held 100 cycles.
  - frame_done pulses at cycle 1000 after START entry.
  - tx_ready returns high the cycle after frame_done.
- Carrier check during the 8'hA5 frame:
  - In the start bit, fsk_out period = 20 cycles (10 high/10 low); in data bit 0, period = 10 cycles.
  - No fsk_out toggle on any bit_tick cycle.
- tx_valid held high continuously with bytes 8'h00 then 8'hFF:
  - Second acceptance occurs exactly 1001 cycles after the first.
  - Second byte unaffected by the first; the all-ones data bits are pure mark carrier.
- Assert rst low at cycle 437 of a frame:
  - All outputs at reset values in the same cycle.
  - After release, a new byte 8'h3C transmits a correct full frame.
- BIT_CYCLES=4, HALF_SPACE=3, HALF_MARK=1:
  - Frame length 40 cycles.
  - Carrier counter resets at each boundary.
  - No X on any output.

Source files
------------

// File: rtl/fsk_pkg.sv
// Shared definitions for the FSK transmit path: FSM states, frame constants
// and the counter-width helper used to size the bit and carrier counters.
package fsk_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } state_t;

  localparam logic START_BIT  = 1'b0;
  localparam logic STOP_BIT   = 1'b1;
  localparam int   DATA_BITS  = 8;
  localparam int   FRAME_BITS = 10;

  // Width of a counter that must hold 0..max_val-1, never narrower than 1 bit.
  function automatic int cnt_width(input int max_val);
    return (max_val < 2) ? 1 : $clog2(max_val);
  endfunction

endpackage

// File: rtl/fsk_carrier_gen.sv
// Square-wave carrier generator. The half-period is chosen per bit
// (mark or space). A phase reset restarts the half-period count without
// moving the output level, so keying between tones is phase-continuous.
module fsk_carrier_gen
  import fsk_pkg::*;
#(
  parameter int HALF_MARK  = 5,
  parameter int HALF_SPACE = 10
) (
  input  logic clk,
  input  logic rst,
  input  logic enable,
  input  logic sel_mark,
  input  logic phase_reset,
  output logic carrier
);

  localparam int HALF_MAX = (HALF_MARK > HALF_SPACE) ? HALF_MARK : HALF_SPACE;
  localparam int CW       = cnt_width(HALF_MAX);

  logic [CW-1:0] car_cnt_reg;
  logic          level_reg;
  logic [CW-1:0] half_last;

  assign half_last = sel_mark ? CW'(HALF_MARK - 1) : CW'(HALF_SPACE - 1);

  // Half-period counter and toggle flop; the bit boundary beats a pending toggle.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      car_cnt_reg <= '0;
      level_reg   <= 1'b0;
    end else if (!enable) begin
      car_cnt_reg <= '0;
      level_reg   <= 1'b0;
    end else if (phase_reset) begin
      car_cnt_reg <= '0;
    end else if (car_cnt_reg == half_last) begin
      car_cnt_reg <= '0;
      level_reg   <= ~level_reg;
    end else begin
      car_cnt_reg <= car_cnt_reg + 1'b1;
    end
  end

  // Gating with enable forces the output low on the very first idle cycle.
  assign carrier = level_reg & enable;

endmodule

// File: rtl/fsk_tx_sequencer.sv
// FSK frame sequencer: accepts a byte on a valid/ready handshake and sends
// it as start bit, 8 data bits LSB first, stop bit, each BIT_CYCLES long,
// keying the carrier generator between mark and space tones.
module fsk_tx_sequencer
  import fsk_pkg::*;
#(
  parameter int BIT_CYCLES = 100,
  parameter int HALF_SPACE = 10,
  parameter int HALF_MARK  = 5
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] tx_data,
  input  logic       tx_valid,
  output logic       tx_ready,
  output logic       fsk_out,
  output logic       busy,
  output logic       bit_tick,
  output logic       cur_bit,
  output logic       frame_done
);

  localparam int            BW       = cnt_width(BIT_CYCLES);
  localparam int            IW       = cnt_width(DATA_BITS);
  localparam logic [BW-1:0] BIT_LAST = BW'(BIT_CYCLES - 1);
  localparam logic [IW-1:0] IDX_LAST = IW'(DATA_BITS - 1);

  state_t                 state_reg, state_next;
  logic [BW-1:0]          bit_cnt_reg, bit_cnt_next;
  logic [IW-1:0]          bit_idx_reg, bit_idx_next;
  logic [DATA_BITS-1:0]   data_sr_reg, data_sr_next;
  logic                   tick;
  logic                   line_bit;

  // State, bit timing and shift register; everything clears on reset.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_reg   <= IDLE;
      bit_cnt_reg <= '0;
      bit_idx_reg <= '0;
      data_sr_reg <= '0;
    end else begin
      state_reg   <= state_next;
      bit_cnt_reg <= bit_cnt_next;
      bit_idx_reg <= bit_idx_next;
      data_sr_reg <= data_sr_next;
    end
  end

  // Next-state logic plus the per-bit outputs derived from the current state.
  always_comb begin
    state_next   = state_reg;
    bit_cnt_next = bit_cnt_reg;
    bit_idx_next = bit_idx_reg;
    data_sr_next = data_sr_reg;
    tick         = 1'b0;
    line_bit     = STOP_BIT;

    if (state_reg != IDLE) begin
      tick         = (bit_cnt_reg == BIT_LAST);
      bit_cnt_next = tick ? '0 : bit_cnt_reg + 1'b1;
    end

    case (state_reg)
      IDLE: begin
        if (tx_valid) begin
          data_sr_next = tx_data;
          bit_cnt_next = '0;
          bit_idx_next = '0;
          state_next   = START;
        end
      end
      START: begin
        line_bit = START_BIT;
        if (tick) begin
          bit_idx_next = '0;
          state_next   = DATA;
        end
      end
      DATA: begin
        line_bit = data_sr_reg[0];
        if (tick) begin
          data_sr_next = {1'b0, data_sr_reg[DATA_BITS-1:1]};
          if (bit_idx_reg == IDX_LAST) begin
            state_next = STOP;
          end else begin
            bit_idx_next = bit_idx_reg + 1'b1;
          end
        end
      end
      STOP: begin
        line_bit = STOP_BIT;
        if (tick) begin
          state_next = IDLE;
        end
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  assign tx_ready   = (state_reg == IDLE);
  assign busy       = (state_reg != IDLE);
  assign bit_tick   = tick;
  assign cur_bit    = line_bit;
  assign frame_done = (state_reg == STOP) && tick;

  fsk_carrier_gen #(
    .HALF_MARK  (HALF_MARK),
    .HALF_SPACE (HALF_SPACE)
  ) u_carrier (
    .clk         (clk),
    .rst         (rst),
    .enable      (busy),
    .sel_mark    (line_bit),
    .phase_reset (tick),
    .carrier     (fsk_out)
  );

endmodule

// File: tb/tb_fsk_tx_sequencer.sv
// Bench for fsk_tx_sequencer: a default-parameter instance driven with the
// directed frames and random bytes, and a small-parameter instance driven
// with random traffic. Both are compared every cycle against a frame-level
// model that derives the expected outputs from the bit position in the frame.
module tb_fsk_tx_sequencer;
  import fsk_pkg::*;

  localparam int B1 = 100, HS1 = 10, HM1 = 5;
  localparam int B2 = 4,   HS2 = 3,  HM2 = 1;
  localparam logic [5:0] IDLE_OUTS = 6'b100010; // {ready,busy,fsk,tick,cur,done}

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] data_b = 8'h00, data_s = 8'h00;
  logic       valid_b = 1'b0, valid_s = 1'b0;
  logic       ready_b, fsk_b, busy_b, tick_b, cur_b, done_b;
  logic       ready_s, fsk_s, busy_s, tick_s, cur_s, done_s;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  fsk_tx_sequencer #(.BIT_CYCLES(B1), .HALF_SPACE(HS1), .HALF_MARK(HM1)) dut_big (
    .clk(clk), .rst(rst), .tx_data(data_b), .tx_valid(valid_b), .tx_ready(ready_b),
    .fsk_out(fsk_b), .busy(busy_b), .bit_tick(tick_b), .cur_bit(cur_b), .frame_done(done_b)
  );

  fsk_tx_sequencer #(.BIT_CYCLES(B2), .HALF_SPACE(HS2), .HALF_MARK(HM2)) dut_small (
    .clk(clk), .rst(rst), .tx_data(data_s), .tx_valid(valid_s), .tx_ready(ready_s),
    .fsk_out(fsk_s), .busy(busy_s), .bit_tick(tick_s), .cur_bit(cur_s), .frame_done(done_s)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // Expected {ready,busy,fsk,tick,cur,done} at cycle t after START entry.
  // The carrier level is the count of half-periods elapsed in the current bit,
  // on top of the level each earlier bit left behind (its last toggle is
  // suppressed by the bit boundary).
  function automatic logic [5:0] expect_outs(input bit act, input int t, input logic [7:0] b,
                                            input int bc, input int hs, input int hm);
    bit bits [FRAME_BITS];
    int k, p, h, lvl;
    if (!act) return IDLE_OUTS;
    bits[0] = START_BIT;
    for (int i = 0; i < DATA_BITS; i++) bits[i+1] = b[i];
    bits[FRAME_BITS-1] = STOP_BIT;
    k = t / bc;
    p = t % bc;
    lvl = 0;
    for (int j = 0; j < k; j++) begin
      h = bits[j] ? hm : hs;
      lvl = lvl ^ (((bc - 1) / h) & 1);
    end
    h = bits[k] ? hm : hs;
    lvl = lvl ^ ((p / h) & 1);
    return {1'b0, 1'b1, lvl[0], (p == bc - 1), bits[k], (t == FRAME_BITS * bc - 1)};
  endfunction

  // Frame-level reference model, one per instance.
  bit         mb_act = 0, ms_act = 0;
  int         mb_t = 0, ms_t = 0;
  logic [7:0] mb_byte = 8'h00, ms_byte = 8'h00;

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      mb_act <= 0;
      mb_t   <= 0;
    end else if (!mb_act) begin
      if (valid_b) begin
        mb_act  <= 1;
        mb_t    <= 0;
        mb_byte <= data_b;
        $display("tx big  : byte %02h accepted at cycle %0d", data_b, cyc);
      end
    end else if (mb_t == FRAME_BITS * B1 - 1) begin
      mb_act <= 0;
    end else begin
      mb_t <= mb_t + 1;
    end
  end

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      ms_act <= 0;
      ms_t   <= 0;
    end else if (!ms_act) begin
      if (valid_s) begin
        ms_act  <= 1;
        ms_t    <= 0;
        ms_byte <= data_s;
        $display("tx small: byte %02h accepted at cycle %0d", data_s, cyc);
      end
    end else if (ms_t == FRAME_BITS * B2 - 1) begin
      ms_act <= 0;
    end else begin
      ms_t <= ms_t + 1;
    end
  end

  // Per-cycle output comparison plus frame-length measurement from busy.
  int run_b = 0, run_s = 0;
  always @(negedge clk) begin
    check("big_outs",   32'({ready_b, busy_b, fsk_b, tick_b, cur_b, done_b}),
          32'(expect_outs(mb_act, mb_t, mb_byte, B1, HS1, HM1)));
    check("small_outs", 32'({ready_s, busy_s, fsk_s, tick_s, cur_s, done_s}),
          32'(expect_outs(ms_act, ms_t, ms_byte, B2, HS2, HM2)));
    if (rst !== 1'b1) begin
      run_b <= 0;
      run_s <= 0;
    end else begin
      if (busy_b === 1'b1) run_b <= run_b + 1;
      else if (run_b != 0) begin
        check("big_frame_len", 32'(run_b), 32'(FRAME_BITS * B1));
        run_b <= 0;
      end
      if (busy_s === 1'b1) run_s <= run_s + 1;
      else if (run_s != 0) begin
        check("small_frame_len", 32'(run_s), 32'(FRAME_BITS * B2));
        run_s <= 0;
      end
    end
  end

  // Offer a byte to the big instance; acc is the cycle count at acceptance.
  task automatic send_big(input logic [7:0] b, input bit hold, output int acc);
    bit seen;
    seen = 0;
    acc = -1;
    valid_b = 1'b1;
    data_b = b;
    for (int i = 0; i < 3000; i++) begin
      if (ready_b === 1'b1) begin
        seen = 1;
        acc = cyc;
        break;
      end
      @(negedge clk);
    end
    check("big_accept_seen", 32'(seen), 32'(1));
    @(negedge clk);
    if (!hold) valid_b = 1'b0;
    data_b = 8'($urandom);
  endtask

  task automatic wait_idle_big();
    for (int i = 0; i < 3000 && busy_b !== 1'b0; i++) @(negedge clk);
    check("big_idle_reached", 32'(busy_b), 32'(0));
  endtask

  int a1, a2, acc;

  initial begin
    #1 rst = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b1;
    repeat (1000) @(negedge clk);

    // 0xA5 frame with default timing.
    send_big(8'hA5, 0, acc);
    wait_idle_big();
    repeat (3) @(negedge clk);

    // valid held high across two bytes: back-to-back acceptance spacing.
    send_big(8'h00, 1, a1);
    send_big(8'hFF, 0, a2);
    check("accept_gap", 32'(a2 - a1), 32'(FRAME_BITS * B1 + 1));
    wait_idle_big();
    repeat (2) @(negedge clk);

    // Reset at cycle 437 of a frame, then a clean 0x3C frame.
    send_big(8'($urandom), 0, acc);
    repeat (437) @(posedge clk);
    #1 rst = 1'b0;
    #1 check("reset_midframe_outs", 32'({ready_b, busy_b, fsk_b, tick_b, cur_b, done_b}),
             32'(IDLE_OUTS));
    repeat (3) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    send_big(8'h3C, 0, acc);
    wait_idle_big();

    // Random bytes with short random gaps; data changes mid-frame.
    for (int f = 0; f < 3; f++) begin
      repeat ($urandom_range(0, 4)) @(negedge clk);
      send_big(8'($urandom), 0, acc);
      for (int i = 0; i < 500; i++) begin
        @(negedge clk);
        data_b = 8'($urandom);
      end
      wait_idle_big();
    end

    // Small instance: random valid and data every cycle.
    for (int i = 0; i < 2500; i++) begin
      @(negedge clk);
      valid_s = ($urandom_range(0, 3) != 0);
      data_s  = 8'($urandom);
    end
    valid_s = 1'b0;
    repeat (60) @(negedge clk);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog expired total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog");
  end

endmodule
